// File: rtl/serial_frame_controller_if.sv
// ---------------------------------------------------------------------------
// serial_frame_controller_if
// Bundles the serial-side and channel-side signals of serial_frame_controller.
//   clkEN      : bit strobe, one serial bit per enabled clk edge
//   SerIn      : serial data in
//   SerOut     : serial data out (pass-through of SerIn)
//   ch_valid   : one-hot channel select while payload is forwarded
//   busy       : controller is inside a frame
//   addr, len  : captured destination channel and payload length field
//   frame_done : one-clk pulse at end of payload
//   frame_cnt  : completed-frame counter (mod 256)
// slave  : the controller side; master : the driver/monitor side.
// ---------------------------------------------------------------------------
interface serial_frame_controller_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned LEN_W  = 4
);
    logic                   clkEN;
    logic                   SerIn;
    logic                   SerOut;
    logic [2**ADDR_W-1:0]   ch_valid;
    logic                   busy;
    logic [ADDR_W-1:0]      addr;
    logic [LEN_W-1:0]       len;
    logic                   frame_done;
    logic [7:0]             frame_cnt;

    modport slave (
        input  clkEN, SerIn,
        output SerOut, ch_valid, busy, addr, len, frame_done, frame_cnt
    );

    modport master (
        output clkEN, SerIn,
        input  SerOut, ch_valid, busy, addr, len, frame_done, frame_cnt
    );
endinterface

// File: rtl/serial_frame_controller.sv
// ---------------------------------------------------------------------------
// serial_frame_controller
// Hunts for the frame header on SerIn, captures a channel address and a
// payload length field, then routes len+1 payload bits to one of 2**ADDR_W
// channels via a one-hot ch_valid.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : serial_frame_controller_if.slave (clkEN, SerIn in; SerOut,
//         ch_valid, busy, addr, len, frame_done, frame_cnt out)
// ---------------------------------------------------------------------------
module serial_frame_controller #(
    parameter int unsigned          HDR_LEN = 6,
    parameter logic [HDR_LEN-1:0]   HDR     = 6'b110101,
    parameter int unsigned          ADDR_W  = 2,
    parameter int unsigned          LEN_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_frame_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA
    } state_t;

    state_t                 state;
    // Only the previous HDR_LEN-1 bits are kept; the oldest bit of a full
    // HDR_LEN history would be shifted out before it could ever be compared.
    logic [HDR_LEN-2:0]     hist;
    logic [HDR_LEN-1:0]     window;
    logic [ADDR_W-1:0]      addr_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       bitcnt;
    logic [7:0]             frame_cnt_r;
    logic                   frame_done_r;
    logic [2**ADDR_W-1:0]   ch_valid_c;

    assign window = {hist, bus.SerIn};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_HUNT;
            hist         <= '0;
            addr_r       <= '0;
            len_r        <= '0;
            bitcnt       <= '0;
            frame_cnt_r  <= '0;
            frame_done_r <= 1'b0;
        end else begin
            // frame_done is a single-clk pulse even when clkEN is low next
            frame_done_r <= 1'b0;
            if (bus.clkEN) begin
                case (state)
                    S_HUNT: begin
                        hist <= window[HDR_LEN-2:0];
                        if (window == HDR) begin
                            state  <= S_ADDR;
                            bitcnt <= '0;
                        end
                    end
                    S_ADDR: begin
                        addr_r <= ADDR_W'({addr_r, bus.SerIn});
                        if (bitcnt == LEN_W'(ADDR_W - 1)) begin
                            state  <= S_LEN;
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    S_LEN: begin
                        len_r <= LEN_W'({len_r, bus.SerIn});
                        if (bitcnt == LEN_W'(LEN_W - 1)) begin
                            state  <= S_DATA;
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == len_r) begin
                            state        <= S_HUNT;
                            hist         <= '0;
                            frame_cnt_r  <= frame_cnt_r + 1'b1;
                            frame_done_r <= 1'b1;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

    always_comb begin
        ch_valid_c = '0;
        if (state == S_DATA) begin
            ch_valid_c[addr_r] = 1'b1;
        end
    end

    assign bus.SerOut     = bus.SerIn;
    assign bus.ch_valid   = ch_valid_c;
    assign bus.busy       = (state != S_HUNT);
    assign bus.addr       = addr_r;
    assign bus.len        = len_r;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_serial_frame_controller.sv
module tb_serial_frame_controller;

    localparam int NB = 1500;

    typedef struct {
        logic       b;
        logic [3:0] chv;
        logic       busy;
        logic       done;
        int         inc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_frame_controller_if #(.ADDR_W(2), .LEN_W(4)) bus ();

    serial_frame_controller #(
        .HDR_LEN(6),
        .HDR(6'b110101),
        .ADDR_W(2),
        .LEN_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int model_cnt = 0;

    vec_t t2[16];
    vec_t t3[16];

    bit         sb[NB];
    logic [3:0] e_chv[NB];
    bit         e_busy[NB];
    bit         e_done[NB];
    logic [7:0] e_cnt[NB];
    int         lim;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic set_in(input logic b, input logic en);
        @(negedge clk);
        bus.SerIn = b;
        bus.clkEN = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(v[n-1-i], 1'b1);
            tick();
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        model_cnt = 0;
    endtask

    task automatic run_table(input vec_t tbl[16], input int n, input int gap,
                             input logic [1:0] ea, input logic [3:0] el, input string nm);
        logic [3:0] nchv;
        for (int i = 0; i < n; i++) begin
            set_in(tbl[i].b, 1'b1);
            chk({nm, "_chv"}, bus.ch_valid, tbl[i].chv);
            chk({nm, "_serout"}, bus.SerOut, tbl[i].b);
            tick();
            chk({nm, "_busy"}, bus.busy, tbl[i].busy);
            chk({nm, "_done"}, bus.frame_done, tbl[i].done);
            model_cnt = (model_cnt + tbl[i].inc) % 256;
            chk({nm, "_cnt"}, bus.frame_cnt, model_cnt);
            nchv = (i + 1 < n) ? tbl[i+1].chv : 4'b0000;
            for (int g = 0; g < gap; g++) begin
                set_in(1'($urandom_range(0, 1)), 1'b0);
                chk({nm, "_gap_chv"}, bus.ch_valid, nchv);
                chk({nm, "_gap_done_pre"}, bus.frame_done, (g == 0) ? tbl[i].done : 1'b0);
                tick();
                chk({nm, "_gap_done"}, bus.frame_done, 1'b0);
                chk({nm, "_gap_busy"}, bus.busy, tbl[i].busy);
                chk({nm, "_gap_cnt"}, bus.frame_cnt, model_cnt);
            end
        end
        chk({nm, "_addr"}, bus.addr, ea);
        chk({nm, "_len"}, bus.len, el);
    endtask

    // Frame-level reference: scan the bit array for headers, then mark the
    // address/length/payload spans that follow each detected header.
    task automatic build_model();
        int k, start, h, p0, pe, c;
        logic [5:0] w;
        logic [1:0] a;
        logic [3:0] l;
        for (int i = 0; i < NB; i++) begin
            e_chv[i] = '0; e_busy[i] = 0; e_done[i] = 0;
        end
        lim = NB;
        k = 0; start = 0;
        while (k < NB) begin
            w = '0;
            if (k >= start + 5)
                for (int j = 0; j < 6; j++) w = {w[4:0], sb[k-5+j]};
            if (k >= start + 5 && w == 6'b110101) begin
                h = k;
                if (h + 7 + 15 >= NB) begin
                    lim = h;
                    break;
                end
                a = {sb[h+1], sb[h+2]};
                l = {sb[h+3], sb[h+4], sb[h+5], sb[h+6]};
                p0 = h + 7;
                pe = p0 + int'(l);
                for (int j = h; j < pe; j++) e_busy[j] = 1;
                for (int j = p0; j <= pe; j++) e_chv[j] = 4'(1 << a);
                e_done[pe] = 1;
                k = pe + 1;
                start = k;
            end else begin
                k++;
            end
        end
        c = 0;
        for (int i = 0; i < NB; i++) begin
            c = (c + int'(e_done[i])) % 256;
            e_cnt[i] = 8'(c);
        end
    endtask

    task automatic gen_stream();
        int n, m, l;
        logic [5:0] hv;
        hv = 6'b110101;
        n = 0;
        while (n < NB - 40) begin
            if ($urandom_range(0, 2) == 0) begin
                m = $urandom_range(1, 8);
                for (int i = 0; i < m; i++) begin sb[n] = 1'($urandom_range(0, 1)); n++; end
            end else begin
                for (int i = 0; i < 6; i++) begin sb[n] = hv[5-i]; n++; end
                for (int i = 0; i < 2; i++) begin sb[n] = 1'($urandom_range(0, 1)); n++; end
                l = $urandom_range(0, 15);
                for (int i = 0; i < 4; i++) begin sb[n] = 1'((l >> (3 - i)) & 1); n++; end
                for (int i = 0; i <= l; i++) begin sb[n] = 1'($urandom_range(0, 1)); n++; end
            end
        end
        while (n < NB) begin sb[n] = 0; n++; end
    endtask

    initial begin
        logic [15:0] s2;
        logic [13:0] s3;
        logic [15:0] p5;
        int dones, gap;

        s2 = 16'b1101011000111011;
        for (int i = 0; i < 16; i++) begin
            t2[i].b    = s2[15-i];
            t2[i].chv  = (i >= 12) ? 4'b0100 : 4'b0000;
            t2[i].busy = (i >= 5 && i < 15);
            t2[i].done = (i == 15);
            t2[i].inc  = (i == 15) ? 1 : 0;
        end
        s3 = 14'b11101010100001;
        for (int i = 0; i < 16; i++) begin
            t3[i].b    = (i < 14) ? s3[13-i] : 1'b0;
            t3[i].chv  = (i == 13) ? 4'b0010 : 4'b0000;
            t3[i].busy = (i >= 6 && i < 13);
            t3[i].done = (i == 13);
            t3[i].inc  = (i == 13) ? 1 : 0;
        end

        bus.clkEN = 1'b0;
        bus.SerIn = 1'b0;
        #12;
        release_reset();

        // 1: reset mid-frame, then idle zeros
        send_bits(32'b110101_10_0011, 12);
        set_in(1'b1, 1'b1);
        chk("pre_rst_chv", bus.ch_valid, 4'b0100);
        assert_reset();
        chk("rst_chv", bus.ch_valid, 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cnt", bus.frame_cnt, 8'd0);
        chk("rst_addr", bus.addr, 2'd0);
        chk("rst_len", bus.len, 4'd0);
        chk("rst_done", bus.frame_done, 1'b0);
        release_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b1);
            tick();
            chk("idle_busy", bus.busy, 1'b0);
        end

        // 2: basic frame; 4: same with clkEN gaps; 3: overlapping header
        run_table(t2, 16, 0, 2'b10, 4'b0011, "basic");
        run_table(t2, 16, 3, 2'b10, 4'b0011, "gated");
        run_table(t3, 14, 0, 2'b01, 4'b0000, "overlap");

        // 5: header pattern inside a 16-bit payload
        p5 = 16'b1101011101010011;
        send_bits(32'b110101_11_1111, 12);
        chk("hip_busy", bus.busy, 1'b1);
        chk("hip_addr", bus.addr, 2'd3);
        chk("hip_len", bus.len, 4'd15);
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            set_in(p5[15-i], 1'b1);
            chk("hip_chv", bus.ch_valid, 4'b1000);
            chk("hip_serout", bus.SerOut, p5[15-i]);
            tick();
            dones += int'(bus.frame_done);
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b1);
            chk("hip_tail_chv", bus.ch_valid, 4'b0000);
            tick();
            dones += int'(bus.frame_done);
        end
        chk("hip_dones", dones, 1);
        model_cnt = (model_cnt + 1) % 256;
        chk("hip_cnt", bus.frame_cnt, model_cnt);

        // 6: counter wrap from a clean reset, then reset during DATA
        assert_reset();
        release_reset();
        for (int f = 0; f < 257; f++) begin
            send_bits(32'(13'b110101_00_0000_0) | 32'((f % 4) << 5) | 32'(f % 2), 13);
            chk("wrap_done", bus.frame_done, 1'b1);
            model_cnt = (model_cnt + 1) % 256;
            if (f == 254 || f == 255 || f == 256)
                chk("wrap_cnt", bus.frame_cnt, model_cnt);
        end
        send_bits(32'b110101_10_0011, 12);
        set_in(1'b1, 1'b1);
        chk("f258_chv", bus.ch_valid, 4'b0100);
        assert_reset();
        chk("f258_rst_chv", bus.ch_valid, 4'b0000);
        chk("f258_rst_busy", bus.busy, 1'b0);
        chk("f258_rst_cnt", bus.frame_cnt, 8'd0);
        release_reset();
        run_table(t2, 16, 0, 2'b10, 4'b0011, "after_rst");

        // randomized stream against the frame-level model
        gen_stream();
        build_model();
        assert_reset();
        release_reset();
        for (int k = 0; k < lim; k++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gap; g++) begin
                set_in(1'($urandom_range(0, 1)), 1'b0);
                tick();
                chk("rnd_gap_done", bus.frame_done, 1'b0);
                chk("rnd_gap_busy", bus.busy, (k > 0) ? e_busy[k-1] : 1'b0);
                chk("rnd_gap_chv", bus.ch_valid, e_chv[k]);
            end
            set_in(sb[k], 1'b1);
            chk("rnd_chv", bus.ch_valid, e_chv[k]);
            chk("rnd_serout", bus.SerOut, sb[k]);
            tick();
            chk("rnd_busy", bus.busy, e_busy[k]);
            chk("rnd_done", bus.frame_done, e_done[k]);
            chk("rnd_cnt", bus.frame_cnt, e_cnt[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
